piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in serial-out shifter: the transmit end of the serial bit stream consumed by
//  the SIPO shift-register receiver. Accepts a WIDTH-bit word via valid/ready handshake,
//  emits it one bit per clk on sdo with a qualifying strobe. Back-to-back words stream gaplessly.
// PARAMETERS
//  WIDTH      3   word width in bits (>=2)
//  MSB_FIRST  1   1: bit WIDTH-1 sent first (receiver shifts left, d enters bit 0); 0: bit 0 first
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  load_valid   in   1      load_data valid; must hold until accepted
//  load_data    in   WIDTH  parallel word to send
//  load_ready   out  1      block can accept a word this cycle
//  sdo          out  1      serial data out (receiver d)
//  sdo_valid    out  1      sdo carries a frame bit this cycle
//  frame_start  out  1      one-cycle pulse on first bit of each frame
//  busy         out  1      frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): state=IDLE, shreg=0, bit_cnt=0; sdo=0,
//    sdo_valid=0, frame_start=0, busy=0, load_ready=1. Frame in progress is discarded.
//  - FSM states: IDLE, SHIFT, PAR (PAR only with macro). 
//    IDLE -> SHIFT on accept. SHIFT -> last bit -> PAR (macro) else IDLE, or SHIFT if new accept.
//    PAR -> IDLE, or SHIFT if new accept.
//  - Accept = load_valid & load_ready at rising clk: load_data -> shreg, bit_cnt=0, state=SHIFT.
//  - load_ready = (state==IDLE) | last_cycle; last_cycle = final data bit (no macro) or PAR.
//    load_valid while load_ready=0 is ignored; data not sampled.
//  - Latency: word accepted at edge N -> first bit on sdo in cycle after edge N; frame occupies
//    WIDTH cycles (WIDTH+1 with macro). Accept on last_cycle -> next frame's first bit follows
//    with zero idle cycles.
//  - SHIFT: sdo = shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0); each edge shreg
//    shifts toward the output end, zero-fill; bit_cnt increments; last bit at bit_cnt==WIDTH-1.
//  - sdo, sdo_valid, frame_start driven from registers only (no comb path from load_* to sdo).
//  - frame_start = 1 exactly when state==SHIFT & bit_cnt==0.
//  - IDLE: sdo=0, sdo_valid=0. bit_cnt width = $clog2(WIDTH), never exceeds WIDTH-1.
// CONFIGURATION
//  PISO_PARITY_EN defined: after WIDTH data bits, one PAR cycle with sdo = even parity
//    (XOR of the word, captured at accept), sdo_valid=1, frame_start=0, busy=1.
//  PISO_PARITY_EN undefined: no PAR state, frame is exactly WIDTH bits, no parity logic.
// STRUCTURE
//  - Shared include piso_pkg.vh: state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PAR=2'd2),
//    default WIDTH, bit-count width macro. Shared with the receiver-side bench.
//  - One sub-module: piso_bit_counter (clear, enable, terminal-count flag at WIDTH-1).
//  - Top holds FSM, shreg, parity register, handshake.
// TESTING (WIDTH=3 unless noted)
//  1. Load 3'b101 from IDLE -> sdo 1,0,1 on 3 cycles, sdo_valid=1 x3, frame_start on cycle 1 only;
//     SIPO receiver (reset, 3 clocks) ends with q=3'b101.
//  2. Hold load_valid with 3'b110 then 3'b011 -> sdo 1,1,0,0,1,1 contiguous, load_ready high on
//     bits 3 and 6, frame_start on bits 1 and 4.
//  3. PISO_PARITY_EN, load 3'b111 -> sdo 1,1,1,1 (parity 1); load 3'b101 -> 1,0,1,0; 4 valid cycles.
//  4. Assert rst on bit 2 of 3'b110 -> same-cycle sdo=0, sdo_valid=0, busy=0, load_ready=1;
//     after release, load 3'b001 -> 0,0,1 clean frame.
//  5. Change load_data while busy with load_valid=1 -> old frame bits unchanged; new word accepted
//     only on last_cycle.
//  6. MSB_FIRST=0, load 3'b100 -> sdo 0,0,1.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: FSM state encoding, default width and counter-width helper shared by the serializer.
package piso_serializer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;
  localparam int DEF_WIDTH = 3;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/piso_serializer_bit_counter.sv
// piso_bit_counter: frame bit index with clear priority over enable and a terminal flag at WIDTH-1.
module piso_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
  assign o_tc  = r_cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in serial-out shifter with gapless back-to-back frames.
// Define PISO_PARITY_EN to append one even-parity bit (PAR state) after each word.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    w_cnt;
  logic             w_tc, w_last, w_accept, w_out;
  logic [WIDTH-1:0] w_shifted;
  assign w_out     = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
  assign load_ready = (r_state == ST_IDLE) || w_last;
  assign w_accept   = load_valid && load_ready;
  assign sdo_valid  = r_state != ST_IDLE;
  assign busy       = r_state != ST_IDLE;
  assign frame_start = (r_state == ST_SHIFT) && (w_cnt == '0);
`ifdef PISO_PARITY_EN
  logic r_par;
  assign w_last = r_state == ST_PAR;
  assign sdo    = (r_state == ST_SHIFT) ? w_out : (r_state == ST_PAR) && r_par;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_par <= 1'b0;
    else if (w_accept) r_par <= ^load_data;
`else
  assign w_last = (r_state == ST_SHIFT) && w_tc;
  assign sdo    = (r_state == ST_SHIFT) && w_out;
`endif
  // Counter clears at the last data bit so it sits at zero for the next frame or parity cycle.
  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept || w_tc),
    .i_en  (r_state == ST_SHIFT),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_shreg <= load_data;
    end else if (r_state == ST_SHIFT) begin
      r_shreg <= w_shifted;
`ifdef PISO_PARITY_EN
      if (w_tc) r_state <= ST_PAR;
`else
      if (w_tc) r_state <= ST_IDLE;
`endif
    end else begin
      r_state <= ST_IDLE;
    end
endmodule
